// File: rtl/vga_timing_gen.sv
// Raster timing generator for 640x480@60 VGA: pixel-enable divider, h/v counters,
// aligned sync/bright decode, per-frame pulses and a frame counter.
module vga_timing_gen #(
   parameter int   CLK_DIV     = 4,
   parameter int   H_SYNC      = 96,
   parameter int   H_BP        = 48,
   parameter int   H_ACTIVE    = 640,
   parameter int   H_FP        = 16,
   parameter int   V_SYNC      = 2,
   parameter int   V_BP        = 33,
   parameter int   V_ACTIVE    = 480,
   parameter int   V_FP        = 10,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        pix_tick,
   output logic [9:0]  hCount,
   output logic [9:0]  vCount,
   output logic        hSync,
   output logic        vSync,
   output logic        bright,
   output logic        frame_start,
   output logic        vblank_start,
   output logic [15:0] frame_count
);

   localparam int         H_TOTAL   = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int         V_TOTAL   = V_SYNC + V_BP + V_ACTIVE + V_FP;
   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_SYNC_E  = 10'(H_SYNC);
   localparam logic [9:0] V_SYNC_E  = 10'(V_SYNC);
   localparam logic [9:0] H_VIS_LO  = 10'(H_SYNC + H_BP);
   localparam logic [9:0] H_VIS_HI  = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
   localparam logic [9:0] V_VIS_LO  = 10'(V_SYNC + V_BP);
   localparam logic [9:0] V_VIS_HI  = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
   localparam logic [9:0] V_BLANK   = 10'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [3:0] DIV_LAST  = 4'(CLK_DIV - 1);

   logic [3:0] div;
   logic [9:0] h_nxt;
   logic [9:0] v_nxt;
   logic       h_wrap;
   logic       frame_wrap;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div      <= '0;
         pix_tick <= 1'b0;
      end else begin
         div      <= (div == DIV_LAST) ? 4'd0 : div + 4'd1;
         pix_tick <= (div == DIV_LAST);
      end
   end

   // Decoding the next count lets sync/bright land in the same clk as the count.
   always_comb begin
      h_wrap     = (hCount == H_LAST);
      h_nxt      = h_wrap ? 10'd0 : hCount + 10'd1;
      v_nxt      = vCount;
      if (h_wrap) begin
         v_nxt = (vCount == V_LAST) ? 10'd0 : vCount + 10'd1;
      end
      frame_wrap = h_wrap && (vCount == V_LAST);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hCount       <= '0;
         vCount       <= '0;
         hSync        <= SYNC_ACTIVE;
         vSync        <= SYNC_ACTIVE;
         bright       <= 1'b0;
         frame_start  <= 1'b0;
         vblank_start <= 1'b0;
         frame_count  <= '0;
      end else begin
         frame_start  <= 1'b0;
         vblank_start <= 1'b0;
         if (pix_tick) begin
            hCount       <= h_nxt;
            vCount       <= v_nxt;
            hSync        <= (h_nxt < H_SYNC_E) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vSync        <= (v_nxt < V_SYNC_E) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            bright       <= (h_nxt >= H_VIS_LO) && (h_nxt <= H_VIS_HI) &&
                            (v_nxt >= V_VIS_LO) && (v_nxt <= V_VIS_HI);
            frame_start  <= frame_wrap;
            vblank_start <= h_wrap && (v_nxt == V_BLANK);
            if (frame_wrap) begin
               frame_count <= frame_count + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: directed vector table on default timing, plus a
// per-clock scan, frame pulses and mid-frame reset on a shrunken raster.
module tb_vga_timing_gen;

   localparam int   S_DIV = 2;
   localparam int   S_HT  = 10;
   localparam int   S_VT  = 8;
   localparam logic S_SA  = 1'b1;

   logic clk = 1'b0;
   logic rst_d_n;
   logic rst_s_n;

   logic        d_tick, d_hs, d_vs, d_br, d_fs, d_vb;
   logic [9:0]  d_h, d_v;
   logic [15:0] d_fc;
   logic        s_tick, s_hs, s_vs, s_br, s_fs, s_vb;
   logic [9:0]  s_h, s_v;
   logic [15:0] s_fc;

   vga_timing_gen dut_d (
      .clk(clk), .reset_n(rst_d_n), .pix_tick(d_tick), .hCount(d_h), .vCount(d_v),
      .hSync(d_hs), .vSync(d_vs), .bright(d_br), .frame_start(d_fs),
      .vblank_start(d_vb), .frame_count(d_fc)
   );

   vga_timing_gen #(
      .CLK_DIV(2), .H_SYNC(2), .H_BP(2), .H_ACTIVE(4), .H_FP(2),
      .V_SYNC(1), .V_BP(2), .V_ACTIVE(3), .V_FP(2), .SYNC_ACTIVE(1'b1)
   ) dut_s (
      .clk(clk), .reset_n(rst_s_n), .pix_tick(s_tick), .hCount(s_h), .vCount(s_v),
      .hSync(s_hs), .vSync(s_vs), .bright(s_br), .frame_start(s_fs),
      .vblank_start(s_vb), .frame_count(s_fc)
   );

   // clock / reset block
   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   int          n;
   logic [41:0] exp_q[$];

   typedef struct {
      int         n;
      logic       tick;
      logic [9:0] h;
      logic [9:0] v;
      logic       hs;
      logic       vs;
   } vec_t;

   vec_t tbl[15];

   function automatic logic [41:0] pack_d();
      return {d_tick, d_hs, d_vs, d_br, d_fs, d_vb, d_fc, d_v, d_h};
   endfunction

   function automatic logic [41:0] pack_s();
      return {s_tick, s_hs, s_vs, s_br, s_fs, s_vb, s_fc, s_v, s_h};
   endfunction

   // Expected small-raster outputs after k clk edges with reset released.
   function automatic logic [41:0] model_s(input int k);
      int   a, h, v, fc;
      logic tick, adv, hs, vs, br, fs, vb;
      a    = (k >= 1) ? (k - 1) / S_DIV : 0;
      tick = (k >= S_DIV) && (k % S_DIV == 0);
      adv  = (k >= S_DIV + 1) && ((k - 1) % S_DIV == 0);
      h    = a % S_HT;
      v    = (a / S_HT) % S_VT;
      fc   = (a / (S_HT * S_VT)) % 65536;
      hs   = (h < 2) ? S_SA : ~S_SA;
      vs   = (v < 1) ? S_SA : ~S_SA;
      br   = (h >= 4) && (h <= 7) && (v >= 3) && (v <= 5);
      fs   = adv && (h == 0) && (v == 0);
      vb   = adv && (h == 0) && (v == 6);
      return {tick, hs, vs, br, fs, vb, 16'(fc), 10'(v), 10'(h)};
   endfunction

   // scoreboard
   task automatic check(input string name, input logic [41:0] act);
      logic [41:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: got %h, scoreboard empty", name, act);
      end else begin
         e = exp_q.pop_front();
         if (act !== e) begin
            errors++;
            $display("FAIL %s: got %h required %h (edge %0d)", name, act, e, n);
         end
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   // driver
   task automatic step();
      @(posedge clk);
      #1;
      n++;
   endtask

   initial begin
      int fs_cnt, vb_cnt, last_fs, fs_early;

      tbl[0]  = '{0,    1'b0, 10'd0,   10'd0, 1'b0, 1'b0};
      tbl[1]  = '{1,    1'b0, 10'd0,   10'd0, 1'b0, 1'b0};
      tbl[2]  = '{3,    1'b0, 10'd0,   10'd0, 1'b0, 1'b0};
      tbl[3]  = '{4,    1'b1, 10'd0,   10'd0, 1'b0, 1'b0};
      tbl[4]  = '{5,    1'b0, 10'd1,   10'd0, 1'b0, 1'b0};
      tbl[5]  = '{8,    1'b1, 10'd1,   10'd0, 1'b0, 1'b0};
      tbl[6]  = '{9,    1'b0, 10'd2,   10'd0, 1'b0, 1'b0};
      tbl[7]  = '{381,  1'b0, 10'd95,  10'd0, 1'b0, 1'b0};
      tbl[8]  = '{384,  1'b1, 10'd95,  10'd0, 1'b0, 1'b0};
      tbl[9]  = '{385,  1'b0, 10'd96,  10'd0, 1'b1, 1'b0};
      tbl[10] = '{3197, 1'b0, 10'd799, 10'd0, 1'b1, 1'b0};
      tbl[11] = '{3200, 1'b1, 10'd799, 10'd0, 1'b1, 1'b0};
      tbl[12] = '{3201, 1'b0, 10'd0,   10'd1, 1'b0, 1'b0};
      tbl[13] = '{6401, 1'b0, 10'd0,   10'd2, 1'b0, 1'b1};
      tbl[14] = '{6785, 1'b0, 10'd96,  10'd2, 1'b1, 1'b1};

      rst_d_n = 1'b0;
      rst_s_n = 1'b0;
      n       = 0;
      repeat (3) @(posedge clk);

      // default timing: directed table
      @(negedge clk);
      rst_d_n = 1'b1;
      n       = 0;
      for (int i = 0; i < 15; i++) begin
         while (n < tbl[i].n) step();
         exp_q.push_back({tbl[i].tick, tbl[i].hs, tbl[i].vs, 3'b000, 16'd0,
                          tbl[i].v, tbl[i].h});
         check($sformatf("dflt_e%0d", tbl[i].n), pack_d());
      end
      rst_d_n = 1'b0;

      // small raster: per-clock scan over more than two frames
      @(negedge clk);
      rst_s_n = 1'b1;
      n       = 0;
      fs_cnt  = 0;
      vb_cnt  = 0;
      last_fs = -1;
      exp_q.push_back(model_s(0));
      check("small_release", pack_s());
      while (n < 411) begin
         step();
         exp_q.push_back(model_s(n));
         check("small_scan", pack_s());
         if (s_fs === 1'b1) begin
            if (last_fs >= 0) check_int("frame_len_clks", n - last_fs, 160);
            last_fs = n;
            fs_cnt++;
         end
         if (s_vb === 1'b1) vb_cnt++;
      end
      check_int("frame_start_count", fs_cnt, 2);
      check_int("vblank_start_count", vb_cnt, 2);

      // mid-frame reset at (5,4) between edges
      #2;
      rst_s_n = 1'b0;
      #1;
      exp_q.push_back(model_s(0));
      check("async_reset_clear", pack_s());
      step();
      exp_q.push_back(model_s(0));
      check("reset_held", pack_s());

      @(negedge clk);
      rst_s_n  = 1'b1;
      n        = 0;
      fs_early = 0;
      exp_q.push_back(model_s(0));
      check("restart_release", pack_s());
      while (n < 200) begin
         step();
         exp_q.push_back(model_s(n));
         check("restart_scan", pack_s());
         if (s_fs === 1'b1 && n <= 160) fs_early++;
      end
      check_int("restart_no_early_frame_start", fs_early, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator for the 640x480@60 Hz VGA path; drives hCount, vCount and bright into the pixel-colour stage, and hSync/vSync to the connector.
- Runs on the 100 MHz board clock with an internal divide-by-CLK_DIV pixel enable (25 MHz at default). No derived clocks.
- Also supplies per-frame pulses and a frame counter, so game logic can step object positions once per frame instead of using free-running delay counters.

Parameters:
- CLK_DIV, 4, board clocks per pixel; legal range 2..16.
- H_SYNC, 96, hSync pulse width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- V_SYNC, 2, vSync pulse width in lines.
- V_BP, 33, vertical back porch in lines.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch in lines.
- SYNC_ACTIVE, 0, level of hSync/vSync during the sync pulse.

Ports:
- clk  in  1  board clock, 100 MHz, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pix_tick  out  1  one-clk pulse each CLK_DIV clks; the counters advance on it.
- hCount  out  10  horizontal position, 0..H_TOTAL-1 (H_TOTAL = sum of the H_* parameters = 800).
- vCount  out  10  vertical position, 0..V_TOTAL-1 (V_TOTAL = sum of the V_* parameters = 525).
- hSync  out  1  horizontal sync.
- vSync  out  1  vertical sync.
- bright  out  1  high inside the visible window.
- frame_start  out  1  one-clk pulse when the counters wrap to (0,0).
- vblank_start  out  1  one-clk pulse when vCount enters the first front-porch line.
- frame_count  out  16  number of completed frames, wraps modulo 2^16.

Behaviour:
- Reset is an already-decided fact: one clock (clk); reset_n is asynchronous and active-low.
- While reset_n is low, every register clears immediately: divider=0, hCount=0, vCount=0, frame_count=0, pix_tick=0, frame_start=0, vblank_start=0, bright=0, hSync=vSync=SYNC_ACTIVE.
- Reset release is synchronous to clk. The first pix_tick occurs CLK_DIV clks after the first clk edge with reset_n high.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pix_tick is registered and is high for exactly the one clk in which the divider wraps.
  - All other outputs change only on the clk edge that follows a cycle with pix_tick high. They hold otherwise.
- Horizontal counter:
  - On each pix_tick, hCount increments.
  - At H_TOTAL-1 it wraps to 0, and vCount increments in the same edge.
  - vCount wraps from V_TOTAL-1 to 0 in the edge where hCount wraps.
- Regions (pixel and line indices):
  - hSync = SYNC_ACTIVE for hCount in [0, H_SYNC-1].
  - Visible h range is [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] = [144, 783].
  - vSync = SYNC_ACTIVE for vCount in [0, V_SYNC-1].
  - Visible v range is [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1] = [35, 514].
  - bright = 1 only when both hCount and vCount are in their visible ranges.
- Alignment:
  - hSync, vSync and bright are registered and valid in the same clk as the hCount/vCount value they describe. There is no one-pixel skew.
  - Implement this by decoding the next-count values.
- Pulses:
  - frame_start is high for the one clk in which the counters become (0,0).
  - In that same edge, frame_count increments, wrapping from 0xFFFF to 0.
  - vblank_start is high for the one clk in which the counters become (0, 515).
  - Neither pulse occurs on reset release: the counters start at (0,0) but no wrap has happened.
- Widths: counters are 10-bit. Parameter sets with H_TOTAL or V_TOTAL greater than 1024 are illegal.
- Reset asserted mid-frame: all outputs return to reset values asynchronously. Counting resumes from (0,0) after release, with no partial pulse.

Test Plan:
- Reset release, default params:
  - First pix_tick exactly 4 clks after release.
  - hCount goes 0 -> 1 on the following edge.
  - hSync=0, vSync=0, bright=0 at (0,0).
- One full line:
  - hSync low for hCount 0..95 and high for 96..799.
  - At vCount=35, bright rises with hCount=144 and falls with hCount=784.
  - Line length is exactly 3200 clks.
- One full frame:
  - vSync low for vCount 0..1.
  - bright never high for vCount <35 or >514.
  - Frame length is exactly 1,680,000 clks.
  - frame_start pulses once per frame, one clk wide.
  - vblank_start pulses once, at (0,515).
- Wrap boundary:
  - At (799,524) the next pix_tick yields (0,0).
  - frame_start=1 and frame_count goes 0 -> 1 in the same clk.
- Frame counter wrap:
  - Force frame_count to 0xFFFF (or run 65536 frames in a short-timing parameter set).
  - The next frame wrap gives 0x0000.
- Mid-frame reset:
  - Assert reset_n low at (400,200) between clk edges.
  - Outputs clear without waiting for clk.
  - After release the counters restart at (0,0) with frame_count=0 and no frame_start pulse.
